// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types, defaults and sizing helper for serial_subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DIGIT = 1;

  // Counter must be at least one bit wide even when a single digit covers the word.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - 1-bit full subtractor cell (x - y - bin)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B with ripple borrow, start/ready/done handshake
// Optional y86 condition codes zf/sf/of when SUB_FLAGS_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_FLAGS_EN
  ,
  output logic             zf,
  output logic             sf,
  output logic             of
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SUB_FLAGS_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;
`endif

  logic [DIGIT:0]   bchain;
  logic [DIGIT-1:0] dig;

  assign bchain[0] = borrow_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_subtractor u_fs (
      .x    (a_sh_q[i]),
      .y    (b_sh_q[i]),
      .bin  (bchain[i]),
      .d    (dig[i]),
      .bout (bchain[i+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SUB_FLAGS_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
`ifdef SUB_FLAGS_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        // Result digits enter at the MSB end so the low digit lands at bit 0 after N shifts.
        diff_d   = {dig, diff_q[WIDTH-1:DIGIT]};
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        borrow_d = bchain[DIGIT];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SUB_FLAGS_EN
          zf_d    = (diff_d == '0);
          sf_d    = diff_d[WIDTH-1];
          of_d    = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUB_FLAGS_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SUB_FLAGS_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SUB_FLAGS_EN
  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (DIGIT=1 and DIGIT=4)
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start4;
  logic [63:0] a_in, b_in;
  logic        ready1, busy1, done1, borrow1;
  logic        ready4, busy4, done4, borrow4;
  logic [63:0] diff1, diff4;
`ifdef SUB_FLAGS_EN
  logic        zf1, sf1, of1, zf4, sf4, of4;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(64), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a_in), .b(b_in),
    .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
`ifdef SUB_FLAGS_EN
    , .zf(zf1), .sf(sf1), .of(of1)
`endif
  );

  serial_subtractor #(.WIDTH(64), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a_in), .b(b_in),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
`ifdef SUB_FLAGS_EN
    , .zf(zf4), .sf(sf4), .of(of4)
`endif
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int sel        = 1;

  logic        ready_m, busy_m, done_m, borrow_m;
  logic [63:0] diff_m;
`ifdef SUB_FLAGS_EN
  logic        zf_m, sf_m, of_m;
`endif

  always_comb begin
    if (sel == 4) begin
      ready_m = ready4; busy_m = busy4; done_m = done4; borrow_m = borrow4; diff_m = diff4;
`ifdef SUB_FLAGS_EN
      zf_m = zf4; sf_m = sf4; of_m = of4;
`endif
    end else begin
      ready_m = ready1; busy_m = busy1; done_m = done1; borrow_m = borrow1; diff_m = diff1;
`ifdef SUB_FLAGS_EN
      zf_m = zf1; sf_m = sf1; of_m = of1;
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 4) start4 = v;
    else          start1 = v;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (ready_m) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check_eq("ready_timeout", 64'd0, 64'd1);
  endtask

  // Reference: plain modular arithmetic on the operands, flags from their y86 definitions.
  task automatic run_op(input int dig, input logic [63:0] a, input logic [63:0] b, input bit disturb);
    int          n, done_cyc, done_pulses, busy_cnt;
    logic [63:0] ed;
    logic        eb, ezf, esf, eof;
    bit          ok;
    sel = dig;
    n   = 64 / dig;
    ed  = a - b;
    eb  = (a < b);
    ezf = (ed == 64'd0);
    esf = ed[63];
    eof = (a[63] != b[63]) && (ed[63] != a[63]);
    wait_ready(ok);
    if (!ok) return;
    a_in = a;
    b_in = b;
    set_start(1'b1);
    step();
    set_start(1'b0);
    a_in = rnd64();
    b_in = rnd64();
    done_cyc = 0; done_pulses = 0; busy_cnt = 0;
    for (int c = 1; c <= n + 2; c++) begin
      if (busy_m) busy_cnt++;
      if (done_m) begin
        done_pulses++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == 1) check_eq("ready_low_in_run", 64'(ready_m), 64'd0);
      if (c == n + 1 || c == n + 2) begin
        check_eq("diff", diff_m, ed);
        check_eq("borrow", 64'(borrow_m), 64'(eb));
`ifdef SUB_FLAGS_EN
        check_eq("zf", 64'(zf_m), 64'(ezf));
        check_eq("sf", 64'(sf_m), 64'(esf));
        check_eq("of", 64'(of_m), 64'(eof));
`endif
      end
      if (c == n + 1) check_eq("ready_low_in_done", 64'(ready_m), 64'd0);
      if (c == n + 2) check_eq("ready_back", 64'(ready_m), 64'd1);
      if (disturb && (c == 10 || c == n + 1)) begin
        a_in = rnd64();
        b_in = rnd64();
        set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
      step();
    end
    set_start(1'b0);
    check_eq("done_cycle", 64'(done_cyc), 64'(n + 1));
    check_eq("done_pulses", 64'(done_pulses), 64'd1);
    check_eq("busy_cycles", 64'(busy_cnt), 64'(n));
  endtask

  task automatic reset_mid_run();
    bit ok;
    int done_seen;
    sel = 1;
    wait_ready(ok);
    if (!ok) return;
    a_in = 64'd1000;
    b_in = 64'd7;
    set_start(1'b1);
    step();
    set_start(1'b0);
    for (int c = 1; c < 30; c++) step();
    rst_n = 1'b0;
    step();
    check_eq("rst_ready", 64'(ready1), 64'd1);
    check_eq("rst_busy", 64'(busy1), 64'd0);
    check_eq("rst_done", 64'(done1), 64'd0);
    check_eq("rst_diff", diff1, 64'd0);
    check_eq("rst_borrow", 64'(borrow1), 64'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (done1 || busy1) done_seen++;
      step();
    end
    check_eq("no_done_after_abort", 64'(done_seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [63:0] ra, rb;
    int          kind, dig;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (3) step();
    check_eq("reset_ready1", 64'(ready1), 64'd1);
    check_eq("reset_busy1", 64'(busy1), 64'd0);
    check_eq("reset_done1", 64'(done1), 64'd0);
    check_eq("reset_diff1", diff1, 64'd0);
    check_eq("reset_borrow1", 64'(borrow1), 64'd0);
    check_eq("reset_ready4", 64'(ready4), 64'd1);
`ifdef SUB_FLAGS_EN
    check_eq("reset_zf1", 64'(zf1), 64'd0);
    check_eq("reset_sf1", 64'(sf1), 64'd0);
    check_eq("reset_of1", 64'(of1), 64'd0);
`endif
    rst_n = 1'b1;
    step();

    run_op(1, 64'd5, 64'd3, 1'b0);
    run_op(1, 64'd3, 64'd5, 1'b0);
    run_op(1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    run_op(4, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    run_op(1, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    run_op(4, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op(1, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b1);
    run_op(4, rnd64(), rnd64(), 1'b1);
    reset_mid_run();
    run_op(1, 64'd100, 64'd42, 1'b0);

    for (int i = 0; i < 16; i++) begin
      dig  = ($urandom_range(0, 1) == 1) ? 4 : 1;
      kind = $urandom_range(0, 3);
      ra   = rnd64();
      rb   = rnd64();
      if (kind == 1) rb = 64'd0;
      if (kind == 2) rb = ra;
      if (kind == 3) rb = {ra[63:8], rb[7:0]};
      run_op(dig, ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
